// File: rtl/channel_cfg_sequencer.sv
// rtl/channel_cfg_sequencer.sv - GPS channel configuration sequencer (optional epoch tick: CHSEQ_EPOCH_EN)
module channel_cfg_sequencer #(
    parameter int DATA_W        = 16,
    parameter int ADDR_W        = 3,
    parameter int NUM_REGS      = 5,
    parameter int SETTLE_CYCLES = 4,
    parameter int EPOCH_CYCLES  = 16368
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       cfg_valid,
    output logic                       cfg_ready,
    input  logic [NUM_REGS*DATA_W-1:0] cfg_words,
    input  logic [2:0]                 cfg_en_mask,
    input  logic                       abort,
    output logic [ADDR_W-1:0]          address,
    output logic [DATA_W-1:0]          data_value,
    output logic                       wr_en,
    output logic                       lo_nco_enable,
    output logic                       ca_nco_enable,
    output logic                       ca_gen_enable,
    output logic                       busy,
    output logic                       done,
    output logic                       epoch_pulse
);

    localparam int CNT_MAX = (NUM_REGS > SETTLE_CYCLES) ? NUM_REGS : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DISABLE,
        S_WRITE,
        S_SETTLE,
        S_EN_GEN,
        S_RUN
    } state_t;

    state_t                     state, state_nx;
    logic [CNT_W-1:0]           cnt, cnt_nx;
    logic [NUM_REGS*DATA_W-1:0] shadow_words;
    logic [2:0]                 shadow_mask;
    logic                       accept;

    logic [ADDR_W-1:0]          address_nx;
    logic [DATA_W-1:0]          data_nx;
    logic                       wr_en_nx, lo_nx, ca_nco_nx, ca_gen_nx, busy_nx, done_nx;

    assign cfg_ready = ((state == S_IDLE) || (state == S_RUN)) && !abort;
    assign accept    = cfg_valid && cfg_ready;

    // Outputs are decoded from the next state and registered, so they line up with the state they describe.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (abort) begin
            state_nx = S_IDLE;
            cnt_nx   = '0;
        end else begin
            case (state)
                S_IDLE:    if (accept) state_nx = S_DISABLE;
                S_DISABLE: begin
                    state_nx = S_WRITE;
                    cnt_nx   = '0;
                end
                S_WRITE: begin
                    if (cnt == CNT_W'(NUM_REGS - 1)) begin
                        state_nx = S_SETTLE;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                        state_nx = S_EN_GEN;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                S_EN_GEN:  state_nx = S_RUN;
                S_RUN:     if (accept) state_nx = S_DISABLE;
                default:   state_nx = S_IDLE;
            endcase
        end

        wr_en_nx   = (state_nx == S_WRITE);
        address_nx = address;
        data_nx    = data_value;
        if (wr_en_nx) begin
            address_nx = ADDR_W'(cnt_nx);
            data_nx    = shadow_words[int'(cnt_nx)*DATA_W +: DATA_W];
        end
        ca_gen_nx = ((state_nx == S_EN_GEN) || (state_nx == S_RUN)) && shadow_mask[2];
        ca_nco_nx = (state_nx == S_RUN) && shadow_mask[1];
        lo_nx     = (state_nx == S_RUN) && shadow_mask[0];
        done_nx   = (state_nx == S_RUN) && (state != S_RUN);
        busy_nx   = (state_nx == S_DISABLE) || (state_nx == S_WRITE) ||
                    (state_nx == S_SETTLE)  || (state_nx == S_EN_GEN);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            cnt           <= '0;
            shadow_words  <= '0;
            shadow_mask   <= '0;
            address       <= '0;
            data_value    <= '0;
            wr_en         <= 1'b0;
            lo_nco_enable <= 1'b0;
            ca_nco_enable <= 1'b0;
            ca_gen_enable <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            state         <= state_nx;
            cnt           <= cnt_nx;
            if (accept) begin
                shadow_words <= cfg_words;
                shadow_mask  <= cfg_en_mask;
            end
            address       <= address_nx;
            data_value    <= data_nx;
            wr_en         <= wr_en_nx;
            lo_nco_enable <= lo_nx;
            ca_nco_enable <= ca_nco_nx;
            ca_gen_enable <= ca_gen_nx;
            busy          <= busy_nx;
            done          <= done_nx;
        end
    end

`ifdef CHSEQ_EPOCH_EN
    localparam int EP_W = (EPOCH_CYCLES > 2) ? $clog2(EPOCH_CYCLES) : 1;

    logic [EP_W-1:0] ep_cnt;

    // Counts only while RUN persists with the LO NCO on; any exit from RUN restarts the epoch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ep_cnt      <= '0;
            epoch_pulse <= 1'b0;
        end else if ((state == S_RUN) && (state_nx == S_RUN) && lo_nco_enable) begin
            if (ep_cnt == EP_W'(EPOCH_CYCLES - 1)) begin
                ep_cnt      <= '0;
                epoch_pulse <= 1'b1;
            end else begin
                ep_cnt      <= ep_cnt + 1'b1;
                epoch_pulse <= 1'b0;
            end
        end else begin
            ep_cnt      <= '0;
            epoch_pulse <= 1'b0;
        end
    end
`else
    assign epoch_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_channel_cfg_sequencer.sv
// tb/tb_channel_cfg_sequencer.sv - scoreboard bench for channel_cfg_sequencer
module tb_channel_cfg_sequencer;

    localparam int DW = 16;
    localparam int AW = 3;
    localparam int NR = 5;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            cfg_valid = 1'b0;
    logic            cfg_ready;
    logic [NR*DW-1:0] cfg_words = '0;
    logic [2:0]      cfg_en_mask = 3'b000;
    logic            abort = 1'b0;
    logic [AW-1:0]   address;
    logic [DW-1:0]   data_value;
    logic            wr_en, lo_nco_enable, ca_nco_enable, ca_gen_enable, busy, done, epoch_pulse;

    channel_cfg_sequencer #(
        .DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .SETTLE_CYCLES(4), .EPOCH_CYCLES(8)
    ) dut (
        .clk(clk), .reset_n(reset_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_words(cfg_words), .cfg_en_mask(cfg_en_mask), .abort(abort),
        .address(address), .data_value(data_value), .wr_en(wr_en),
        .lo_nco_enable(lo_nco_enable), .ca_nco_enable(ca_nco_enable),
        .ca_gen_enable(ca_gen_enable), .busy(busy), .done(done), .epoch_pulse(epoch_pulse)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    // kind: 0 = register write, 1 = done with enables, 2 = epoch tick
    typedef struct {
        int           kind;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [2:0]   en;
        int           cyc;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input int kind, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [2:0] en, input int c);
        exp_t e;
        e.kind = kind; e.addr = a; e.data = d; e.en = en; e.cyc = c;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (reset_n && (wr_en || done || epoch_pulse)) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event: wr_en=%b done=%b epoch=%b at cyc %0d, none expected",
                         wr_en, done, epoch_pulse, cyc);
            end else begin
                exp_t e;
                logic ok;
                e = exp_q.pop_front();
                case (e.kind)
                    0:       ok = wr_en && !done && address == e.addr && data_value == e.data;
                    1:       ok = done && !wr_en &&
                                  {ca_gen_enable, ca_nco_enable, lo_nco_enable} == e.en;
                    default: ok = epoch_pulse && !done && !wr_en;
                endcase
                if (!ok || cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL sb_kind%0d: got cyc=%0d wr=%b done=%b epoch=%b addr=%0d data=0x%h en=%b; expected cyc=%0d addr=%0d data=0x%h en=%b",
                             e.kind, cyc, wr_en, done, epoch_pulse, address, data_value,
                             {ca_gen_enable, ca_nco_enable, lo_nco_enable}, e.cyc, e.addr, e.data, e.en);
                end
            end
        end
    end

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string name);
        chk(name, {address, data_value, wr_en, lo_nco_enable, ca_nco_enable, ca_gen_enable,
                   busy, done, epoch_pulse, cfg_ready}, {3'd0, 16'd0, 8'b0000_0001});
    endtask

    task automatic chk_quiet(input string name);
        chk(name, {wr_en, lo_nco_enable, ca_nco_enable, ca_gen_enable, busy, done, cfg_ready},
            7'b000_0001);
    endtask

    // Issue a job at a falling edge; returns the counter value seen during cycle 1.
    task automatic start_job(input logic [NR*DW-1:0] w, input logic [2:0] m, input int nwr,
                             input bit with_done, output int a);
        chk("ready_before_accept", cfg_ready, 1'b1);
        cfg_words = w; cfg_en_mask = m; cfg_valid = 1'b1;
        a = cyc + 1;
        for (int k = 0; k < nwr; k++) push(0, AW'(k), w[k*DW +: DW], 3'b000, a + 1 + k);
        if (with_done) push(1, '0, '0, m, a + 11);
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic full_job(input logic [NR*DW-1:0] w, input logic [2:0] m, output int a);
        start_job(w, m, NR, 1'b1, a);
        chk("cycle1_enables_low", {ca_gen_enable, ca_nco_enable, lo_nco_enable, busy, cfg_ready},
            5'b000_10);
        wait_to(a + 10);
        chk("cycle11_gen_only", {ca_gen_enable, ca_nco_enable, lo_nco_enable, busy, cfg_ready},
            {m[2], 2'b00, 2'b10});
        wait_to(a + 11);
        chk("cycle12_run", {busy, cfg_ready}, 2'b01);
        wait_to(a + 12);
        chk("cycle13_held", {ca_gen_enable, ca_nco_enable, lo_nco_enable, done}, {m, 1'b0});
    endtask

    initial begin
        int a;
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        // reset state
        #12;
        chk_reset_vals("reset_asserted");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        chk_reset_vals("idle_after_reset");

        // main job, all enables
        full_job({16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'h1111}, 3'b111, a);
        repeat (2) @(negedge clk);

        // reconfigure from RUN, LO NCO only
        full_job({16'hE0E5, 16'hD0D4, 16'hC0C3, 16'hB0B2, 16'hA0A1}, 3'b001, a);
        repeat (2) @(negedge clk);

        // abort at cycle 4 with a competing request
        start_job({16'h0505, 16'h0404, 16'h0303, 16'h0202, 16'h0101}, 3'b111, 3, 1'b0, a);
        wait_to(a + 3);
        abort = 1'b1; cfg_valid = 1'b1; cfg_words = '1; cfg_en_mask = 3'b111;
        #1 chk("abort_blocks_ready", cfg_ready, 1'b0);
        @(negedge clk);
        abort = 1'b0; cfg_valid = 1'b0;
        #1 chk_quiet("idle_after_abort");
        chk("addr_held_after_abort", {address, data_value}, {3'd2, 16'h0303});
        repeat (15) @(negedge clk);
        chk_quiet("no_job_after_abort");

        // abort and valid together in IDLE: abort wins
        abort = 1'b1; cfg_valid = 1'b1;
        #1 chk("abort_wins_idle", cfg_ready, 1'b0);
        @(negedge clk);
        abort = 1'b0; cfg_valid = 1'b0;
        #1 chk_quiet("idle_abort_not_taken");
        @(negedge clk);

        // asynchronous reset in SETTLE
        start_job({16'h9999, 16'h8888, 16'h7777, 16'h6666, 16'h5A5A}, 3'b111, NR, 1'b0, a);
        wait_to(a + 7);
        chk("in_settle_busy", {busy, wr_en}, 2'b10);
        #2 reset_n = 1'b0;
        #1 chk_reset_vals("async_reset_mid_settle");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk_reset_vals("after_async_reset");
        full_job({16'h1234, 16'h2345, 16'h3456, 16'h4567, 16'h5678}, 3'b110, a);
        repeat (3) @(negedge clk);

        // empty mask still completes
        full_job({16'hFFFF, 16'h0000, 16'hAAAA, 16'h5555, 16'h0001}, 3'b000, a);
        repeat (2) @(negedge clk);

        // epoch ticks with the LO NCO running
`ifdef CHSEQ_EPOCH_EN
        start_job({16'hCAFE, 16'hBEEF, 16'hF00D, 16'hD00D, 16'hFEED}, 3'b001, NR, 1'b1, a);
        push(2, '0, '0, 3'b000, a + 19);
        push(2, '0, '0, 3'b000, a + 27);
        push(2, '0, '0, 3'b000, a + 35);
`else
        start_job({16'hCAFE, 16'hBEEF, 16'hF00D, 16'hD00D, 16'hFEED}, 3'b001, NR, 1'b1, a);
`endif
        wait_to(a + 37);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1 chk_quiet("idle_after_epoch_abort");
        repeat (30) @(negedge clk);
        chk_quiet("quiet_after_epoch_abort");

        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
